time_counter: RTL
=================

// Module: time_counter
// PURPOSE
//  24-hour BCD timekeeping core for the clock design: counts seconds/minutes/hours from a
//  1 Hz enable pulse and applies the adjust commands issued by the mode/adjust state machine
//  (SECCLR, MININC, HOURINC). Also gates each digit pair with that machine's blink enables
//  (SECON, MINON, HOURON) to drive the 7-segment decoder/scan stage.
// PARAMETERS
//  HOUR_MOD      24     hour wrap modulus; legal values 12 (count 0..11) or 24 (count 0..23)
//  BLANK_NIBBLE  4'hF   BCD code driven on a blanked digit; the decoder shows it as all-off
// PORTS
//  CLK       in   1  system clock; all state updates on rising edge
//  RST       in   1  asynchronous, active-low reset
//  EN1HZ     in   1  one-CLK-wide pulse, once per second
//  SECCLR    in   1  one-CLK-wide pulse: clear seconds to 00
//  MININC    in   1  one-CLK-wide pulse: minutes +1
//  HOURINC   in   1  one-CLK-wide pulse: hours +1
//  SECON     in   1  1 = seconds digits visible, 0 = blanked
//  MINON     in   1  1 = minutes digits visible, 0 = blanked
//  HOURON    in   1  1 = hours digits visible, 0 = blanked
//  SEC       out  8  seconds, packed BCD {tens,ones}, 00..59, ungated
//  MIN       out  8  minutes, packed BCD, 00..59, ungated
//  HOUR      out  8  hours, packed BCD, 00..HOUR_MOD-1, ungated
//  DSEC      out  8  SEC, or {BLANK_NIBBLE,BLANK_NIBBLE} when SECON=0
//  DMIN      out  8  MIN, or blank pair when MINON=0
//  DHOUR     out  8  HOUR, or blank pair when HOURON=0
//  DAYPULSE  out  1  one-CLK pulse when time rolls from last hour:59:59 to 00:00:00
// BEHAVIOUR
//  - Reset (RST=0, async): SEC=MIN=HOUR=8'h00, DAYPULSE=0; held while RST=0. D* outputs follow
//    SEC/MIN/HOUR and ON inputs, so reset shows 00 or blank per ON.
//  - Counters are registers; a sampled event is visible on outputs after that same CLK edge.
//    D* outputs are combinational from counters and ON inputs (0-cycle blanking latency).
//  - BCD: ones digit 9 -> 0 with tens +1; seconds/minutes 59 -> 00; hours HOUR_MOD-1 -> 00.
//    Digits never leave legal BCD range; no binary intermediate is exposed.
//  - EN1HZ: seconds +1. Carry to minutes only when SEC=59; carry to hours only when SEC=59
//    and MIN=59. DAYPULSE=1 for exactly the cycle after the 23:59:59 -> 00:00:00 edge.
//  - SECCLR: seconds <= 00, no carry, no minute change. Wins over EN1HZ in the same cycle
//    (result 00, and any pending carry from SEC=59 is discarded).
//  - MININC: minutes +1 mod 60, never carries into hours. If seconds carry coincides,
//    minutes still advance by exactly 1 (events merge, no double step).
//  - HOURINC: hours +1 mod HOUR_MOD, no DAYPULSE. If a minute carry coincides, hours advance
//    by exactly 1; coincident carry into 00 via HOURINC does not raise DAYPULSE.
//  - Adjust pulses are independent: SECCLR, MININC, HOURINC in one cycle all take effect.
//  - Adjust inputs held high for N cycles act N times; upstream guarantees single pulses.
//  - No state machine beyond the three cascaded mod counters; no stall input, time keeps
//    running during adjust.
//  - Reset asserted mid-count clears immediately; first EN1HZ after release gives 00:00:01.
// TESTING
//  1 Reset, 3 EN1HZ pulses -> SEC=8'h03, MIN=HOUR=8'h00, DAYPULSE never 1.
//  2 Preload to 09:59:59 via adjust pulses, EN1HZ -> 10:00:00 (ones-to-tens BCD carry on hours).
//  3 At 23:59:59, EN1HZ -> 00:00:00 and DAYPULSE high exactly one cycle; HOUR_MOD=12
//    build: 11:59:59 -> 00:00:00.
//  4 SEC=59 with SECCLR and EN1HZ same cycle -> SEC=00, MIN unchanged; MIN=59 + MININC ->
//    MIN=00, HOUR unchanged.
//  5 SEC=59,MIN=10: EN1HZ+MININC same cycle -> MIN=11 (not 12); HOURINC at 23 -> 00,
//    DAYPULSE stays 0.
//  6 SECON toggled 0/1 at 2 Hz with SEC=8'h42 -> DSEC alternates 8'hFF/8'h42 same cycle;
//    DMIN, DHOUR unaffected.

Source files
------------

// File: rtl/time_counter.sv
// 24-hour (or 12-hour) BCD time-of-day counter with adjust inputs.
// Drives per-pair blanking for the 7-segment scan stage.
module time_counter #(
  parameter int          HOUR_MOD     = 24,
  parameter logic [3:0]  BLANK_NIBBLE = 4'hF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SECCLR,
  input  logic       MININC,
  input  logic       HOURINC,
  input  logic       SECON,
  input  logic       MINON,
  input  logic       HOURON,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic [7:0] HOUR,
  output logic [7:0] DSEC,
  output logic [7:0] DMIN,
  output logic [7:0] DHOUR,
  output logic       DAYPULSE
);

  localparam int         HLAST     = HOUR_MOD - 1;
  localparam logic [7:0] HOUR_LAST =
    8'((HLAST / 10) * 16 + (HLAST % 10));
  localparam logic [7:0] MS_LAST   = 8'h59;
  localparam logic [7:0] BLANK     = {BLANK_NIBBLE, BLANK_NIBBLE};

  // Packed-BCD increment that wraps to 00 after `last`.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] last
  );
    logic [7:0] r;
    r = {v[7:4], v[3:0] + 4'd1};
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic       sec_carry;
  logic       min_carry;
  logic       min_step;
  logic       hour_step;
  logic       day_roll;
  logic [7:0] sec_nxt;
  logic [7:0] min_nxt;
  logic [7:0] hour_nxt;

  assign sec_wrap  = (SEC == MS_LAST);
  assign min_wrap  = (MIN == MS_LAST);
  assign hour_wrap = (HOUR == HOUR_LAST);

  // A clear in the same cycle swallows the seconds carry.
  assign sec_carry = EN1HZ & ~SECCLR & sec_wrap;
  assign min_carry = sec_carry & min_wrap;

  // Manual and carry steps merge into a single increment.
  assign min_step  = MININC | sec_carry;
  assign hour_step = HOURINC | min_carry;
  assign day_roll  = min_carry & hour_wrap & ~HOURINC;

  always_comb begin
    sec_nxt = SEC;
    if (SECCLR)
      sec_nxt = 8'h00;
    else if (EN1HZ)
      sec_nxt = bcd_inc(SEC, MS_LAST);
  end

  always_comb begin
    min_nxt = MIN;
    if (min_step)
      min_nxt = bcd_inc(MIN, MS_LAST);
  end

  always_comb begin
    hour_nxt = HOUR;
    if (hour_step)
      hour_nxt = bcd_inc(HOUR, HOUR_LAST);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEC      <= 8'h00;
      MIN      <= 8'h00;
      HOUR     <= 8'h00;
      DAYPULSE <= 1'b0;
    end else begin
      SEC      <= sec_nxt;
      MIN      <= min_nxt;
      HOUR     <= hour_nxt;
      DAYPULSE <= day_roll;
    end
  end

  assign DSEC  = SECON  ? SEC  : BLANK;
  assign DMIN  = MINON  ? MIN  : BLANK;
  assign DHOUR = HOURON ? HOUR : BLANK;

endmodule
